param_icache: RTL and testbench

- Parametrised, read-only, set-associative instruction cache between the IF stage (slave side) and the AXI read channel (master side).
- Successor to the fixed 2-way/128-set icache. Adds:
  - configurable ways, sets and line length;
  - per-set round-robin replacement that prefers invalid ways;
  - an explicit request-accept handshake;
  - per-set and whole-cache invalidate;
  - flush-safe miss handling.

---
 rtl/param_icache.sv | 272 +++++++++++++++++++++++++++
 tb/tb_param_icache.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_icache.sv
// Parametrised set-associative read-only instruction cache with AXI burst refill.
// Define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module param_icache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8,
  localparam int OFF_W = $clog2(LINE_WORDS) + 2,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 32 - IDX_W - OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cache_ena,
  input  logic [31:0]      s_araddr,
  input  logic             s_arvalid,
  output logic             s_arready,
  output logic [31:0]      s_rdata,
  output logic             s_rvalid,
  input  logic             flush,
  input  logic             inv_set,
  input  logic [IDX_W-1:0] inv_index,
  input  logic             inv_all,
  output logic [31:0]      m_araddr,
  output logic [7:0]       m_arlen,
  output logic             m_arvalid,
  input  logic             m_arready,
  input  logic [31:0]      m_rdata,
  input  logic             m_rvalid,
  input  logic             m_rlast,
  output logic             m_rready
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
`endif
);

  localparam int WO_W  = $clog2(LINE_WORDS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BC_W  = WO_W + 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, REFILL, RESP} state_t;

  state_t                     state_q, state_d;
  logic [31:0]                addr_q, addr_d;
  logic                       cached_q, cached_d;
  logic                       killed_q, killed_d;
  logic [WAY_W-1:0]           victim_q, victim_d;
  logic [WO_W-1:0]            beat_q, beat_d;
  logic [BC_W-1:0]            beats_q, beats_d;
  logic [31:0]                rdata_q, rdata_d;
  logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;
  logic                       pend_all_q, pend_all_d;
  logic                       pend_set_q, pend_set_d;
  logic [IDX_W-1:0]           pend_idx_q, pend_idx_d;

  logic [WO_W-1:0]            req_off, rd_off;
  logic [IDX_W-1:0]           req_idx, rd_idx;
  logic [TAG_W-1:0]           req_tag;
  logic [WAYS-1:0][31:0]      data_rd;
  logic [WAYS-1:0]            hit_vec;
  logic [31:0]                hit_word;
  logic [WAY_W-1:0]           victim_sel;
  logic                       data_we, tag_we;

  assign req_off = addr_q[OFF_W-1:2];
  assign req_idx = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign req_tag = addr_q[31:OFF_W+IDX_W];
  // Memories are read with the incoming address in IDLE so LOOKUP sees data one cycle later.
  assign rd_off  = (state_q == IDLE) ? s_araddr[OFF_W-1:2] : req_off;
  assign rd_idx  = (state_q == IDLE) ? s_araddr[OFF_W+IDX_W-1:OFF_W] : req_idx;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_out;
    logic [31:0]      data_out;
    logic             sel;

    assign sel = (victim_q == WAY_W'(gi));

    always_ff @(posedge clk) begin
      if (tag_we && sel) tag_mem[req_idx] <= req_tag;
      tag_out <= tag_mem[rd_idx];
    end

    always_ff @(posedge clk) begin
      if (data_we && sel) data_mem[{req_idx, beat_q}] <= m_rdata;
      data_out <= data_mem[{rd_idx, rd_off}];
    end

    assign data_rd[gi] = data_out;
    assign hit_vec[gi] = valid_q[req_idx][gi] && (tag_out == req_tag);
  end

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_word = hit_word | data_rd[w];
  end

  // Lowest-numbered invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    victim_sel = rr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[req_idx][w]) victim_sel = WAY_W'(w);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cached_d   = cached_q;
    killed_d   = killed_q;
    victim_d   = victim_q;
    beat_d     = beat_q;
    beats_d    = beats_q;
    rdata_d    = rdata_q;
    valid_d    = valid_q;
    rr_d       = rr_q;
    pend_all_d = pend_all_q;
    pend_set_d = pend_set_q;
    pend_idx_d = pend_idx_q;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rdata    = '0;
    m_araddr   = '0;
    m_arlen    = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    data_we    = 1'b0;
    tag_we     = 1'b0;

    if (state_q != IDLE) begin
      if (inv_all) pend_all_d = 1'b1;
      if (inv_set) begin
        // A second, different set index cannot be held separately; widen to a full invalidate.
        if (pend_set_q && (pend_idx_q != inv_index)) pend_all_d = 1'b1;
        pend_set_d = 1'b1;
        pend_idx_d = inv_index;
      end
      if (flush && (state_q != LOOKUP)) killed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        pend_all_d = 1'b0;
        pend_set_d = 1'b0;
        if (inv_all || pend_all_q) begin
          valid_d = '0;
        end else begin
          if (pend_set_q) valid_d[pend_idx_q] = '0;
          if (inv_set)    valid_d[inv_index]  = '0;
        end
        s_arready = s_arvalid && !flush && !inv_set && !inv_all &&
                    !pend_all_q && !pend_set_q && !rst;
        if (s_arready) begin
          addr_d   = s_araddr;
          cached_d = cache_ena;
          killed_d = 1'b0;
          beat_d   = '0;
          beats_d  = '0;
          state_d  = cache_ena ? LOOKUP : MISS_AR;
        end
      end
      LOOKUP: begin
        if (flush) begin
          state_d = IDLE;
        end else if (|hit_vec) begin
          s_rvalid = 1'b1;
          s_rdata  = hit_word;
          state_d  = IDLE;
        end else begin
          victim_d = victim_sel;
          state_d  = MISS_AR;
        end
      end
      MISS_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = cached_q ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : addr_q;
        m_arlen   = cached_q ? 8'(LINE_WORDS - 1) : 8'd0;
        if (m_arready) state_d = REFILL;
      end
      REFILL: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          data_we = cached_q;
          if (!cached_q || (beat_q == req_off)) rdata_d = m_rdata;
          beat_d = beat_q + 1'b1;
          if (beats_q != '1) beats_d = beats_q + 1'b1;
          if (m_rlast) state_d = RESP;
        end
      end
      RESP: begin
        s_rvalid = !killed_q && !flush;
        s_rdata  = rdata_q;
        if (cached_q && (beats_q == BC_W'(LINE_WORDS))) begin
          tag_we                     = 1'b1;
          valid_d[req_idx][victim_q] = 1'b1;
          rr_d[req_idx] = (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
        end
        killed_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cached_q   <= 1'b0;
      killed_q   <= 1'b0;
      victim_q   <= '0;
      beat_q     <= '0;
      beats_q    <= '0;
      rdata_q    <= '0;
      valid_q    <= '0;
      rr_q       <= '0;
      pend_all_q <= 1'b0;
      pend_set_q <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cached_q   <= cached_d;
      killed_q   <= killed_d;
      victim_q   <= victim_d;
      beat_q     <= beat_d;
      beats_q    <= beats_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      pend_all_q <= pend_all_d;
      pend_set_q <= pend_set_d;
      pend_idx_q <= pend_idx_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        hit_inc, miss_inc;

  assign hit_inc  = (state_q == LOOKUP) && !flush && (|hit_vec);
  assign miss_inc = (state_q == LOOKUP) && !flush && !(|hit_vec);

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
                                 (state_q == LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_param_icache.sv
// Directed bench for param_icache (WAYS=2, SETS=128, LINE_WORDS=8) with an inline AXI memory model.
module tb_param_icache;

  logic        clk;
  logic        rst;
  logic        cache_ena;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        flush;
  logic        inv_set;
  logic [6:0]  inv_index;
  logic        inv_all;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int errors;
  int checks;

  param_icache #(.WAYS(2), .SETS(128), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .cache_ena(cache_ena),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .flush(flush), .inv_set(inv_set), .inv_index(inv_index), .inv_all(inv_all),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        ena;
    logic [31:0] base;
    int          flush_beat;
    int          inv_beat;
    int          exp_ar;
    logic [31:0] exp_araddr;
    logic [7:0]  exp_arlen;
    int          exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input int id, input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", id, what, got, exp);
    end
  endtask

  // Presents one fetch, plays the AXI slave (ready one cycle after valid, bursts of base+i),
  // then idles for a fixed window and checks what was observed.
  task automatic run_vec(input vec_t v, input int id);
    int n_ar, n_rv, nbeats, acc_cyc, rv_cyc, last_cyc, beat, burst_len;
    logic [31:0] ar_addr, rd, hold_addr;
    logic [7:0]  ar_len;
    bit accepted, ar_wait, in_burst, held;
    n_ar = 0; n_rv = 0; nbeats = 0; acc_cyc = -1; rv_cyc = -1; last_cyc = -1;
    beat = 0; burst_len = 0; ar_addr = '0; rd = '0; hold_addr = '0; ar_len = '0;
    accepted = 0; ar_wait = 0; in_burst = 0; held = 0;
    @(posedge clk); #1;
    s_araddr = v.addr; cache_ena = v.ena; s_arvalid = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      m_arready = ar_wait;
      m_rvalid  = in_burst;
      m_rdata   = v.base + 32'(beat);
      m_rlast   = in_burst && (beat == burst_len - 1);
      flush     = in_burst && (beat == v.flush_beat);
      inv_set   = in_burst && (beat == v.inv_beat);
      inv_index = v.addr[11:5];
      #1;
      if (s_arready && !accepted) begin accepted = 1; acc_cyc = cyc; end
      if (s_rvalid) begin n_rv++; rd = s_rdata; rv_cyc = cyc; end
      if (m_rvalid && m_rready) begin
        nbeats++;
        if (m_rlast) begin last_cyc = cyc; in_burst = 0; end
        beat++;
      end
      if (m_arvalid && m_arready) begin
        n_ar++; ar_addr = m_araddr; ar_len = m_arlen;
        if (held) chk(id, "ar_stable", m_araddr, hold_addr);
        ar_wait = 0; held = 0; in_burst = 1; beat = 0; burst_len = int'(m_arlen) + 1;
      end else if (m_arvalid) begin
        ar_wait = 1; held = 1; hold_addr = m_araddr;
      end
      @(posedge clk); #1;
      if (accepted) s_arvalid = 1'b0;
      if (!accepted && cyc >= 20) break;
      if (accepted && (cyc - acc_cyc) >= 24) break;
    end
    s_arvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    flush = 1'b0; inv_set = 1'b0;
    $display("vec %0d addr=%08h ena=%0d ar=%0d araddr=%08h arlen=%0d beats=%0d rv=%0d rdata=%08h",
             id, v.addr, v.ena, n_ar, ar_addr, ar_len, nbeats, n_rv, rd);
    chk(id, "accepted", 32'(accepted), 32'd1);
    chk(id, "ar_count", 32'(n_ar), 32'(v.exp_ar));
    if (v.exp_ar != 0) begin
      chk(id, "araddr", ar_addr, v.exp_araddr);
      chk(id, "arlen", 32'(ar_len), 32'(v.exp_arlen));
      chk(id, "beats", 32'(nbeats), 32'(v.exp_arlen) + 32'd1);
    end
    chk(id, "rvalid_count", 32'(n_rv), 32'(v.exp_rv));
    if (v.exp_rv != 0) begin
      chk(id, "rdata", rd, v.exp_rdata);
      if (v.exp_ar == 0) chk(id, "hit_latency", 32'(rv_cyc - acc_cyc), 32'd1);
      else               chk(id, "rlast_to_rvalid", 32'(rv_cyc - last_cyc), 32'd1);
    end
  endtask

  task automatic chk_outputs_zero(input int id);
    chk(id, "s_arready_zero", 32'(s_arready), 32'd0);
    chk(id, "s_rvalid_zero",  32'(s_rvalid),  32'd0);
    chk(id, "s_rdata_zero",   s_rdata,        32'd0);
    chk(id, "m_arvalid_zero", 32'(m_arvalid), 32'd0);
    chk(id, "m_araddr_zero",  m_araddr,       32'd0);
    chk(id, "m_arlen_zero",   32'(m_arlen),   32'd0);
    chk(id, "m_rready_zero",  32'(m_rready),  32'd0);
  endtask

  vec_t vt [15];
  vec_t v;
  bit   in_refill, acc;

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; cache_ena = 1'b0; s_araddr = '0; s_arvalid = 1'b0;
    flush = 1'b0; inv_set = 1'b0; inv_index = '0; inv_all = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0; m_rlast = 1'b0;

    vt[0]  = '{32'hBFC00004, 1'b1, 32'h1000,     -1, -1, 1, 32'hBFC00000, 8'd7, 1, 32'h1001};
    vt[1]  = '{32'hBFC0001C, 1'b1, 32'h9900,     -1, -1, 0, 32'h0,        8'd0, 1, 32'h1007};
    vt[2]  = '{32'h000100A0, 1'b1, 32'h2000,     -1, -1, 1, 32'h000100A0, 8'd7, 1, 32'h2000};
    vt[3]  = '{32'h000200A0, 1'b1, 32'h3000,     -1, -1, 1, 32'h000200A0, 8'd7, 1, 32'h3000};
    vt[4]  = '{32'h000300A0, 1'b1, 32'h4000,     -1, -1, 1, 32'h000300A0, 8'd7, 1, 32'h4000};
    vt[5]  = '{32'h000200A8, 1'b1, 32'h9900,     -1, -1, 0, 32'h0,        8'd0, 1, 32'h3002};
    vt[6]  = '{32'h000100A0, 1'b1, 32'h2100,     -1, -1, 1, 32'h000100A0, 8'd7, 1, 32'h2100};
    vt[7]  = '{32'h000300BC, 1'b1, 32'h9900,     -1, -1, 0, 32'h0,        8'd0, 1, 32'h4007};
    vt[8]  = '{32'h1FC00008, 1'b0, 32'hDEADBEEF, -1, -1, 1, 32'h1FC00008, 8'd0, 1, 32'hDEADBEEF};
    vt[9]  = '{32'h1FC00008, 1'b0, 32'hDEADBEEF, -1, -1, 1, 32'h1FC00008, 8'd0, 1, 32'hDEADBEEF};
    vt[10] = '{32'h1FC00008, 1'b1, 32'h5000,     -1, -1, 1, 32'h1FC00000, 8'd7, 1, 32'h5002};
    vt[11] = '{32'h00050120, 1'b1, 32'h6000,      3, -1, 1, 32'h00050120, 8'd7, 0, 32'h0};
    vt[12] = '{32'h00050124, 1'b1, 32'h9900,     -1, -1, 0, 32'h0,        8'd0, 1, 32'h6001};
    vt[13] = '{32'h00070180, 1'b1, 32'h7000,     -1,  2, 1, 32'h00070180, 8'd7, 1, 32'h7000};
    vt[14] = '{32'h00070184, 1'b1, 32'h7100,     -1, -1, 1, 32'h00070180, 8'd7, 1, 32'h7101};

    repeat (3) @(posedge clk);
    #2;
    chk_outputs_zero(100);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vt[i], i);

    // inv_set together with a request: request refused, set 0 cleared.
    @(posedge clk); #1;
    s_araddr = 32'hBFC0001C; cache_ena = 1'b1; s_arvalid = 1'b1;
    inv_set = 1'b1; inv_index = 7'd0;
    #1;
    chk(101, "arready_during_inv", 32'(s_arready), 32'd0);
    @(posedge clk); #1;
    inv_set = 1'b0; s_arvalid = 1'b0;
    v = '{32'hBFC0001C, 1'b1, 32'h8000, -1, -1, 1, 32'hBFC00000, 8'd7, 1, 32'h8007};
    run_vec(v, 15);

    // inv_all drops the previously hitting line of set 9.
    @(posedge clk); #1;
    inv_all = 1'b1;
    @(posedge clk); #1;
    inv_all = 1'b0;
    v = '{32'h00050124, 1'b1, 32'h9000, -1, -1, 1, 32'h00050120, 8'd7, 1, 32'h9001};
    run_vec(v, 16);

    // Fresh reset, then one miss and three hits.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    v = '{32'h000B0000, 1'b1, 32'hA000, -1, -1, 1, 32'h000B0000, 8'd7, 1, 32'hA000};
    run_vec(v, 17);
    for (int i = 1; i <= 3; i++) begin
      v = '{32'h000B0000 + 32'(4 * i), 1'b1, 32'h9900, -1, -1, 0, 32'h0, 8'd0, 1, 32'hA000 + 32'(i)};
      run_vec(v, 17 + i);
    end
`ifdef ICACHE_STATS_EN
    chk(102, "hit_cnt", hit_cnt, 32'd3);
    chk(102, "miss_cnt", miss_cnt, 32'd1);
`endif

    // Asynchronous reset in the middle of a refill.
    in_refill = 0; acc = 0;
    @(posedge clk); #1;
    s_araddr = 32'h000A0200; cache_ena = 1'b1; s_arvalid = 1'b1; m_arready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m_rready) begin in_refill = 1; break; end
      if (s_arready) acc = 1;
      @(posedge clk); #1;
      if (acc) s_arvalid = 1'b0;
    end
    chk(103, "reached_refill", 32'(in_refill), 32'd1);
    s_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rlast = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_outputs_zero(103);
`ifdef ICACHE_STATS_EN
    chk(103, "hit_cnt_reset", hit_cnt, 32'd0);
    chk(103, "miss_cnt_reset", miss_cnt, 32'd0);
`endif
    m_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
